// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, addresses the 32-word ROM and holds one registered instruction for decode.
// Optional macro PC_BOUND_CHECK_EN: fault on out-of-region PC instead of modulo wrap.
module fetch_sequencer #(
    parameter int unsigned MEM_DEPTH = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    input  logic        instr_ready,
    input  logic [31:0] rom_rd,
    output logic [31:0] rom_a,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic        halted,
    output logic        fault
);

    localparam logic [31:0] SPAN = 32'(MEM_DEPTH * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_HALT
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_instr_valid;
    logic        r_halted;

    state_t      w_state;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic [31:0] w_pc_out;
    logic        w_instr_valid;
    logic        w_halted;

    logic        w_advance;
    logic [31:0] w_target;
    logic [31:0] w_seq_pc;
    logic [31:0] w_branch_pc;

`ifdef PC_BOUND_CHECK_EN
    logic        r_fault;
    logic        w_fault;
    logic        w_seq_oob;
    logic        w_tgt_oob;

    // Unsigned offset compare also catches addresses below RESET_PC.
    function automatic logic in_region(input logic [31:0] a);
        return (a - RESET_PC) < SPAN;
    endfunction

    assign w_seq_pc    = r_pc + 32'd4;
    assign w_branch_pc = w_target;
    assign w_seq_oob   = !in_region(w_seq_pc);
    assign w_tgt_oob   = !in_region(w_target);
    assign fault       = r_fault;
`else
    function automatic logic [31:0] wrap_addr(input logic [31:0] a);
        return RESET_PC + ((a - RESET_PC) & (SPAN - 32'd1));
    endfunction

    assign w_seq_pc    = wrap_addr(r_pc + 32'd4);
    assign w_branch_pc = wrap_addr(w_target);
    assign fault       = 1'b0;
`endif

    assign w_advance = !r_instr_valid || instr_ready;
    assign w_target  = branch_target & ~32'h3;

    // Branch beats halt detection, which beats capture, which beats stall.
    always_comb begin
        w_state       = r_state;
        w_pc          = r_pc;
        w_instr       = r_instr;
        w_pc_out      = r_pc_out;
        w_instr_valid = r_instr_valid;
        w_halted      = r_halted;
`ifdef PC_BOUND_CHECK_EN
        w_fault       = r_fault;
`endif
        case (r_state)
            S_IDLE: begin
                w_instr_valid = 1'b0;
                if (start) begin
                    w_state = S_FETCH;
                end
            end
            S_FETCH, S_HOLD: begin
                if (branch_en) begin
                    w_instr_valid = 1'b0;
                    w_state       = S_FETCH;
`ifdef PC_BOUND_CHECK_EN
                    if (w_tgt_oob) begin
                        w_fault  = 1'b1;
                        w_halted = 1'b1;
                        w_state  = S_HALT;
                    end else begin
                        w_pc = w_branch_pc;
                    end
`else
                    w_pc = w_branch_pc;
`endif
                end else if (w_advance) begin
                    if (rom_rd == HALT_WORD) begin
                        w_instr_valid = 1'b0;
                        w_halted      = 1'b1;
                        w_state       = S_HALT;
`ifdef PC_BOUND_CHECK_EN
                    end else if (w_seq_oob) begin
                        w_instr_valid = 1'b0;
                        w_fault       = 1'b1;
                        w_halted      = 1'b1;
                        w_state       = S_HALT;
`endif
                    end else begin
                        w_instr       = rom_rd;
                        w_pc_out      = r_pc;
                        w_instr_valid = 1'b1;
                        w_pc          = w_seq_pc;
                        w_state       = S_FETCH;
                    end
                end else begin
                    w_state = S_HOLD;
                end
            end
            S_HALT: begin
                w_instr_valid = 1'b0;
                w_halted      = 1'b1;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_pc_out      <= 32'd0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
`ifdef PC_BOUND_CHECK_EN
            r_fault       <= 1'b0;
`endif
        end else begin
            r_state       <= w_state;
            r_pc          <= w_pc;
            r_instr       <= w_instr;
            r_pc_out      <= w_pc_out;
            r_instr_valid <= w_instr_valid;
            r_halted      <= w_halted;
`ifdef PC_BOUND_CHECK_EN
            r_fault       <= w_fault;
`endif
        end
    end

    assign rom_a       = r_pc;
    assign instr       = r_instr;
    assign pc_out      = r_pc_out;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;

endmodule
